// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master (START, 7-bit address + R/W,
// one data byte, STOP). Every bit slot is 4*DIV clk cycles split into four
// quarter-phases. SCL/SDA are open-drain style: 1 releases the line, 0 pulls low.
`timescale 1ns/1ps
module i2c_master_ctrl #(
  parameter int DIV = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_o,
  output logic       sda_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_ADDR_ACK = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_DATA_ACK = 3'd5;
  localparam logic [2:0] S_STOP     = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0] state;
  logic [7:0] cnt;
  logic [1:0] phase;
  logic [2:0] bitcnt;
  logic       rw_q;
  logic [7:0] addr_rw;
  logic [7:0] wdata_q;

  logic cnt_end;
  logic slot_end;
  logic sample;

  assign cnt_end  = (cnt == 8'(DIV - 1));
  assign slot_end = cnt_end && (phase == 2'd3);
  // SDA is read on the last cycle SCL is high.
  assign sample   = cnt_end && (phase == 2'd2);

  // Quarter-phase timebase; held at zero outside active slots so the first
  // slot starts cleanly on the acceptance edge.
  // NOTE: registered state uses non-blocking assignments so every flop
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= '0;
    end else if (state == S_IDLE || state == S_DONE) begin
      cnt   <= '0;
      phase <= '0;
    end else if (cnt_end) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Transaction sequencer: captures the request, shifts bits, records ACKs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      bitcnt  <= '0;
      rw_q    <= 1'b0;
      addr_rw <= '0;
      wdata_q <= '0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bitcnt <= '0;
          if (start) begin
            rw_q    <= rw;
            addr_rw <= {addr, rw};
            wdata_q <= wdata;
            ack_err <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: if (slot_end) state <= S_ADDR;
        S_ADDR: begin
          if (slot_end) begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (sample && sda_i) ack_err <= 1'b1;
          // ack_err was cleared on acceptance, so here it reflects only
          // the address acknowledge sampled earlier in this slot.
          if (slot_end) state <= ack_err ? S_STOP : S_DATA;
        end
        S_DATA: begin
          if (sample && rw_q) rdata <= {rdata[6:0], sda_i};
          if (slot_end) begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= S_DATA_ACK;
          end
        end
        S_DATA_ACK: begin
          if (sample && !rw_q && sda_i) ack_err <= 1'b1;
          if (slot_end) state <= S_STOP;
        end
        S_STOP: if (slot_end) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line drive decoded from state/phase/bit index; reset forces IDLE, so
  // both lines release immediately without waiting for a clock edge.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    case (state)
      S_START: begin
        sda_o = (phase < 2'd2);
        scl_o = (phase != 2'd3);
      end
      S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK: begin
        scl_o = (phase == 2'd1) || (phase == 2'd2);
        if (state == S_ADDR)
          sda_o = addr_rw[3'd7 - bitcnt];
        else if (state == S_DATA && !rw_q)
          sda_o = wdata_q[3'd7 - bitcnt];
      end
      S_STOP: begin
        scl_o = (phase != 2'd0);
        sda_o = (phase >= 2'd2);
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed bench for i2c_master_ctrl at DIV=12.
// A small slave model answers on SDA; master SDA drive is recorded at every
// SCL rising edge and compared against hand-built bit sequences.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;

  localparam int DIV = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       sda_i = 1'b1;
  logic       busy, done, ack_err, scl_o, sda_o;
  logic [7:0] rdata;

  int checks = 0;
  int failures = 0;

  // slave model configuration
  logic       s_rw = 1'b0;
  logic       s_anack = 1'b0;
  logic [7:0] s_rbyte = '0;

  int   nrise = 0;
  int   dcount = 0;
  logic prev_scl = 1'b1;
  logic bits[$];

  i2c_master_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .sda_i(sda_i), .busy(busy), .done(done),
    .ack_err(ack_err), .rdata(rdata), .scl_o(scl_o), .sda_o(sda_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Level the slave drives during SCL-high of bit slot k (1-based).
  function automatic logic slave_bit(input int k);
    if (k == 9) return s_anack;
    if (k >= 10 && k <= 17) return s_rw ? s_rbyte[17 - k] : 1'b1;
    if (k == 18) return s_rw;
    return 1'b1;
  endfunction

  // Slave/monitor: records master SDA at SCL rise, updates sda_i on SCL fall.
  always @(negedge clk) begin
    if (rst || !busy) begin
      nrise    = 0;
      prev_scl = 1'b1;
      sda_i    = 1'b1;
      bits.delete();
    end else begin
      if (scl_o && !prev_scl) begin
        nrise++;
        bits.push_back(sda_o);
      end
      if (!scl_o && prev_scl) sda_i = slave_bit(nrise + 1);
      prev_scl = scl_o;
    end
    if (done) dcount++;
  end

  task automatic set_req(input logic r, input logic [6:0] a,
                         input logic [7:0] wd, input logic an,
                         input logic [7:0] rb);
    rw = r; addr = a; wdata = wd;
    s_rw = r; s_anack = an; s_rbyte = rb;
  endtask

  // Raise start for one edge (the acceptance edge, cycle 0).
  task automatic accept;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after cycle 0 until done; optional spurious start at 100.
  task automatic wait_done(input bit spurious, output int n);
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      if (spurious && i == 101) start = 1'b1;
      @(posedge clk);
      #1;
      if (spurious && i == 101) start = 1'b0;
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) $display("FAIL wait_done: got timeout expected done pulse");
  endtask

  function automatic logic [31:0] pack_bits;
    logic [31:0] v = '0;
    foreach (bits[i]) v = {v[30:0], bits[i]};
    return v;
  endfunction

  int n;
  int d0;

  initial begin
    // reset state, observed while rst is held
    #12;
    check("rst_scl", 32'(scl_o), 32'd1);
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_lines", {30'd0, scl_o, sda_o}, 32'd3);

    // write 0x50 <- 0xA5, both ACKed; spurious start at cycle 100
    set_req(1'b0, 7'h50, 8'hA5, 1'b0, 8'h00);
    d0 = dcount;
    accept();
    check("wr_busy", 32'(busy), 32'd1);
    wait_done(1'b1, n);
    check("wr_done_cycle", 32'(n), 32'd960);
    check("wr_busy_at_done", 32'(busy), 32'd1);
    check("wr_ack_err", 32'(ack_err), 32'd0);
    check("wr_nbits", 32'(bits.size()), 32'd19);
    check("wr_bits", pack_bits(), 32'b1010000_0_1_10100101_1_0);
    repeat (3) @(posedge clk);
    #1;
    check("wr_one_done", 32'(dcount - d0), 32'd1);
    check("wr_idle_busy", 32'(busy), 32'd0);

    // read 0x3C, slave returns 0x5A, master NACKs
    set_req(1'b1, 7'h3C, 8'h00, 1'b0, 8'h5A);
    accept();
    wait_done(1'b0, n);
    check("rd_done_cycle", 32'(n), 32'd960);
    check("rd_rdata", 32'(rdata), 32'h5A);
    check("rd_ack_err", 32'(ack_err), 32'd0);
    check("rd_bits", pack_bits(), 32'b0111100_1_1_11111111_1_0);
    repeat (3) @(posedge clk);

    // address NACK: no data slots, STOP directly
    set_req(1'b0, 7'h22, 8'hC3, 1'b1, 8'h00);
    accept();
    wait_done(1'b0, n);
    check("an_done_cycle", 32'(n), 32'd528);
    check("an_ack_err", 32'(ack_err), 32'd1);
    check("an_nbits", 32'(bits.size()), 32'd10);
    check("an_bits", pack_bits(), 32'b0100010_0_1_0);
    check("an_rdata_held", 32'(rdata), 32'h5A);
    repeat (3) @(posedge clk);

    // reset mid DATA bit 3 (slot 13 spans cycles 624..671)
    set_req(1'b0, 7'h11, 8'h0F, 1'b0, 8'h00);
    accept();
    repeat (640) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_scl", 32'(scl_o), 32'd1);
    check("mrst_sda", 32'(sda_o), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_rdata", 32'(rdata), 32'd0);
    set_req(1'b0, 7'h50, 8'hA5, 1'b0, 8'h00);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    check("mrst_accept", 32'(busy), 32'd1);
    wait_done(1'b0, n);
    check("mrst_done_cycle", 32'(n), 32'd960);
    check("mrst_bits", pack_bits(), 32'b1010000_0_1_10100101_1_0);
    repeat (3) @(posedge clk);

    // start held high: back-to-back transactions
    set_req(1'b1, 7'h3C, 8'h00, 1'b0, 8'hC6);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1'b0, n);
    check("b2b_first_cycle", 32'(n), 32'd960);
    check("b2b_first_rdata", 32'(rdata), 32'hC6);
    @(posedge clk);
    #1;
    check("b2b_idle_gap", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("b2b_reaccept", 32'(busy), 32'd1);
    wait_done(1'b0, n);
    start = 1'b0;
    check("b2b_second_cycle", 32'(n), 32'd960);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_end_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 12, meaning clk cycles per SCL quarter-phase; legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  transaction request; sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  0 = write, 1 = read; captured with start.
REQ-006 SHALL have port addr  input  7  target address; captured with start.
REQ-007 SHALL have port wdata  input  8  write byte; captured with start.
REQ-008 SHALL have port sda_i  input  1  sampled SDA line level.
REQ-009 SHALL have port busy  output  1  high from acceptance through done cycle.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ack_err  output  1  NACK seen in last transaction; valid with done, held until next acceptance.
REQ-012 SHALL have port rdata  output  8  read byte; valid with done when rw=1, held until next read.
REQ-013 SHALL have port scl_o  output  1  SCL drive; 1 = released (high), 0 = pull low.
REQ-014 SHALL have port sda_o  output  1  SDA drive; 1 = released, 0 = pull low.

Function
REQ-015 SHALL have states IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE.
REQ-016 SHALL in IDLE with start=1 capture rw/addr/wdata, clear ack_err, and go to START; that edge is cycle 0.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL drive a tick counter 0..DIV-1 from cycle 0 and advance phase 0..3 when counter = DIV-1; each bit slot spans 4*DIV cycles.
REQ-019 SHALL generate data-bit slots (ADDR, ADDR_ACK, DATA, DATA_ACK) as:
  - phase 0: scl_o=0, sda_o updated;
  - phases 1-2: scl_o=1;
  - phase 3: scl_o=0;
  - sda_i sampled at the last cycle of phase 2.
REQ-020 SHALL make the START slot phases 0-1 sda_o=1 scl_o=1, phase 2 sda_o=0 scl_o=1, phase 3 sda_o=0 scl_o=0.
REQ-021 SHALL make the STOP slot phase 0 sda_o=0 scl_o=0, phase 1 sda_o=0 scl_o=1, phases 2-3 sda_o=1 scl_o=1.
REQ-022 SHALL in ADDR shift out {addr, rw} MSB first over 8 slots.
REQ-023 SHALL in ADDR_ACK release SDA; sda_i=1 sets ack_err and goes to STOP; otherwise goes to DATA.
REQ-024 SHALL in DATA shift out wdata MSB first when rw=0.
REQ-025 SHALL in DATA shift sda_i into rdata MSB first with SDA released when rw=1.
REQ-026 SHALL in DATA_ACK with rw=0 release SDA, and sda_i=1 sets ack_err.
REQ-027 SHALL in DATA_ACK with rw=1 drive the master NACK (sda_o=1).
REQ-028 SHALL go from DATA_ACK to STOP regardless of ack.
REQ-029 SHALL after STOP phase 3 enter DONE for exactly one cycle with done=1 and busy=1, then go to IDLE.
REQ-030 SHALL produce the full transaction done pulse in cycle 80*DIV.
REQ-031 SHALL produce the address-NACK done pulse in cycle 44*DIV.
REQ-032 SHALL hold scl_o=1, sda_o=1, busy=0 in IDLE.

Reset
REQ-033 SHALL on rst=1 immediately, without waiting for clk, force:
  - state IDLE, counters 0;
  - scl_o=1, sda_o=1;
  - busy=0, done=0, ack_err=0, rdata=0.
REQ-034 SHALL on rst asserted mid-transaction abort with no STOP generated and accept a new start on the first edge after release.

Verification
REQ-035 SHALL cover: DIV=12, write addr=0x50 wdata=0xA5, slave ACKs both -> SDA bits 1010000_0 then 10100101; done at cycle 960; ack_err=0.
REQ-036 SHALL cover: read addr=0x3C, slave returns 0x5A -> rdata=0x5A; master NACK on 9th data slot; done at cycle 960.
REQ-037 SHALL cover: address NACK (sda_i=1 in ADDR_ACK) -> no DATA slots; STOP follows; done at cycle 528; ack_err=1.
REQ-038 SHALL cover: start pulsed at cycle 100 of an active transaction -> ignored; exactly one done pulse.
REQ-039 SHALL cover: rst asserted mid-cycle during DATA bit 3 -> scl_o=1, sda_o=1, busy=0 before next clk edge; next start completes normally.
REQ-040 SHALL cover: start held high continuously -> back-to-back transactions, each done pulse followed by acceptance one cycle later in IDLE.
